// File: rtl/usb_pkt_logger.sv
// ----------------------------------------------------------------------------
// usb_pkt_logger
//   Captures one received USB packet at a time into a payload buffer and
//   replays it as a compact byte-stream record on a valid/ready output:
//     [TS0 TS1] HDR LEN [TOK0 TOK1 | payload bytes]
//   HDR = {valid_packet, overflow, 2'b00, pid}, LEN = captured byte count.
//   Packets that start while a record is still draining are dropped and
//   counted (saturating).
//
//   Optional feature: define USB_PKT_LOGGER_TIMESTAMP_EN to add a 16-bit
//   free-running cycle counter, latched at pkt_start, emitted as TS0/TS1
//   ahead of HDR.
//
// Ports
//   clk           system clock (receiver clock domain)
//   reset         asynchronous active-low reset
//   pkt_start     single-cycle start-of-packet strobe
//   pkt_end       single-cycle end-of-packet strobe
//   pid           4-bit PID, sampled at pkt_end
//   frame_num     11-bit token frame/address field, sampled at pkt_end
//   valid_packet  receiver's packet-OK flag, sampled at pkt_end
//   rx_data_put   received-byte strobe
//   rx_data       received byte
//   out_data      record byte
//   out_valid     record byte valid
//   out_ready     downstream accepts record byte
//   drop_count    saturating count of packets dropped while busy
// ----------------------------------------------------------------------------
module usb_pkt_logger #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pkt_start,
    input  logic        pkt_end,
    input  logic [3:0]  pid,
    input  logic [10:0] frame_num,
    input  logic        valid_packet,
    input  logic        rx_data_put,
    input  logic [7:0]  rx_data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;   // count spans 0..DEPTH inclusive

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_CAPTURE = 4'd1;
    localparam logic [3:0] S_HDR     = 4'd2;
    localparam logic [3:0] S_LEN     = 4'd3;
    localparam logic [3:0] S_TOK0    = 4'd6;
    localparam logic [3:0] S_TOK1    = 4'd7;
    localparam logic [3:0] S_PAYLOAD = 4'd8;
`ifdef USB_PKT_LOGGER_TIMESTAMP_EN
    localparam logic [3:0] S_TS0     = 4'd4;
    localparam logic [3:0] S_TS1     = 4'd5;
    localparam logic [3:0] S_FIRST   = S_TS0;
`else
    localparam logic [3:0] S_FIRST   = S_HDR;
`endif

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;
    logic [3:0]    pid_q, pid_d;
    logic [10:0]   frame_q, frame_d;
    logic          vld_q, vld_d;
    logic [7:0]    drop_q, drop_d;
    logic          mem_we;
    logic          accept;
    logic [8:0]    cnt_ext;
    logic [7:0]    len_byte;
    logic          hdr_ovf;

    logic [7:0]    mem [DEPTH];

`ifdef USB_PKT_LOGGER_TIMESTAMP_EN
    logic [15:0]   ts_cnt_q, ts_cnt_d;
    logic [15:0]   ts_q, ts_d;
`endif

    // A full DEPTH=256 buffer cannot be expressed in one LEN byte; it is
    // reported as 8'hFF and flagged as overflow.
    assign cnt_ext  = 9'(wr_ptr_q);
    assign len_byte = cnt_ext[8] ? 8'hFF : cnt_ext[7:0];
    assign hdr_ovf  = ovf_q | cnt_ext[8];
    assign accept   = out_valid & out_ready;
    assign drop_count = drop_q;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        pid_d    = pid_q;
        frame_d  = frame_q;
        vld_d    = vld_q;
        drop_d   = drop_q;
        mem_we   = 1'b0;
`ifdef USB_PKT_LOGGER_TIMESTAMP_EN
        ts_cnt_d = ts_cnt_q + 16'd1;
        ts_d     = ts_q;
`endif
        case (state_q)
            S_IDLE, S_CAPTURE: begin
                if (pkt_start) begin
                    // A new start always wins: any partial capture is thrown away.
                    state_d  = S_CAPTURE;
                    wr_ptr_d = '0;
                    ovf_d    = 1'b0;
`ifdef USB_PKT_LOGGER_TIMESTAMP_EN
                    ts_d     = ts_cnt_q;
`endif
                end else if (state_q == S_CAPTURE) begin
                    if (rx_data_put) begin
                        if (wr_ptr_q < CW'(DEPTH)) begin
                            mem_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + CW'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    // wr_ptr/ovf stay frozen after this point and serve as
                    // the latched count/overflow for the record.
                    if (pkt_end) begin
                        pid_d    = pid;
                        frame_d  = frame_num;
                        vld_d    = valid_packet;
                        rd_ptr_d = '0;
                        state_d  = S_FIRST;
                    end
                end
            end
            default: begin
                if (pkt_start && drop_q != 8'hFF)
                    drop_d = drop_q + 8'd1;
                if (accept) begin
                    case (state_q)
`ifdef USB_PKT_LOGGER_TIMESTAMP_EN
                        S_TS0: state_d = S_TS1;
                        S_TS1: state_d = S_HDR;
`endif
                        S_HDR: state_d = S_LEN;
                        S_LEN: begin
                            case (pid_q[1:0])
                                2'b01:   state_d = S_TOK0;
                                2'b11:   state_d = (wr_ptr_q != '0) ? S_PAYLOAD : S_IDLE;
                                default: state_d = S_IDLE;
                            endcase
                        end
                        S_TOK0: state_d = S_TOK1;
                        S_TOK1: state_d = S_IDLE;
                        S_PAYLOAD: begin
                            if (rd_ptr_q == wr_ptr_q - CW'(1))
                                state_d = S_IDLE;
                            else
                                rd_ptr_d = rd_ptr_q + CW'(1);
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    // Output byte is a pure function of state and latched fields, so it is
    // naturally stable while the consumer stalls.
    always_comb begin
        out_valid = 1'b1;
        out_data  = 8'h00;
        case (state_q)
`ifdef USB_PKT_LOGGER_TIMESTAMP_EN
            S_TS0:     out_data = ts_q[7:0];
            S_TS1:     out_data = ts_q[15:8];
`endif
            S_HDR:     out_data = {vld_q, hdr_ovf, 2'b00, pid_q};
            S_LEN:     out_data = len_byte;
            S_TOK0:    out_data = frame_q[7:0];
            S_TOK1:    out_data = {5'b0, frame_q[10:8]};
            S_PAYLOAD: out_data = mem[rd_ptr_q[AW-1:0]];
            default:   out_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            pid_q    <= '0;
            frame_q  <= '0;
            vld_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            pid_q    <= pid_d;
            frame_q  <= frame_d;
            vld_q    <= vld_d;
            drop_q   <= drop_d;
        end
    end

`ifdef USB_PKT_LOGGER_TIMESTAMP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_d;
            ts_q     <= ts_d;
        end
    end
`endif

    // Buffer contents survive reset; only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_ptr_q[AW-1:0]] <= rx_data;
    end

endmodule

// File: tb/tb_usb_pkt_logger.sv
module tb_usb_pkt_logger;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pkt_start = 1'b0;
    logic        pkt_end = 1'b0;
    logic [3:0]  pid = '0;
    logic [10:0] frame_num = '0;
    logic        valid_packet = 1'b0;
    logic        rx_data_put = 1'b0;
    logic [7:0]  rx_data = '0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  drop_count;

    int tests = 0;
    int fails = 0;
    logic [7:0]  tx_q [$];
    logic [15:0] ts_exp = '0;

    usb_pkt_logger #(.DEPTH(64)) dut (
        .clk(clk), .reset(reset), .pkt_start(pkt_start), .pkt_end(pkt_end),
        .pid(pid), .frame_num(frame_num), .valid_packet(valid_packet),
        .rx_data_put(rx_data_put), .rx_data(rx_data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

`ifdef USB_PKT_LOGGER_TIMESTAMP_EN
    logic [15:0] tb_cyc;
    always @(posedge clk or negedge reset)
        if (!reset) tb_cyc <= '0;
        else        tb_cyc <= tb_cyc + 16'd1;
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a byte, check it, let it be accepted (out_ready=1).
    task automatic rec_byte(input string tag, input logic [7:0] exp);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 16'(out_valid), 16'd1);
        chk(tag, 16'(out_data), 16'(exp));
        @(negedge clk);
    endtask

    task automatic ts_bytes();
`ifdef USB_PKT_LOGGER_TIMESTAMP_EN
        rec_byte("ts0", ts_exp[7:0]);
        rec_byte("ts1", ts_exp[15:8]);
`endif
    endtask

    // Send a packet whose n payload bytes come from tx_q; the last byte
    // coincides with pkt_end. Returns on the negedge after pkt_end.
    task automatic send_pkt(input logic [3:0] p, input logic [10:0] f, input logic v, input int n);
        pkt_start = 1'b1;
`ifdef USB_PKT_LOGGER_TIMESTAMP_EN
        ts_exp = tb_cyc;
`endif
        @(negedge clk);
        pkt_start = 1'b0;
        if (n == 0) begin
            pkt_end = 1'b1; pid = p; frame_num = f; valid_packet = v;
            @(negedge clk);
        end
        for (int i = 0; i < n; i++) begin
            rx_data_put = 1'b1;
            rx_data = tx_q[i];
            if (i == n - 1) begin
                pkt_end = 1'b1; pid = p; frame_num = f; valid_packet = v;
            end
            @(negedge clk);
        end
        rx_data_put = 1'b0;
        pkt_end = 1'b0;
    endtask

    initial begin
        logic stable;

        // reset state
        #1;
        chk("rst_valid", 16'(out_valid), 16'd0);
        chk("rst_data", 16'(out_data), 16'h00);
        chk("rst_drop", 16'(drop_count), 16'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // pkt_end in IDLE is ignored
        pkt_end = 1'b1; pid = 4'b0011;
        @(negedge clk);
        pkt_end = 1'b0;
        chk("idle_end_ignored", 16'(out_valid), 16'd0);
        @(negedge clk);

        // IN token
        send_pkt(4'b1001, 11'h0A5, 1'b1, 0);
        chk("tok_valid_next", 16'(out_valid), 16'd1);
        ts_bytes();
        rec_byte("tok_hdr", 8'h89);
        rec_byte("tok_len", 8'h00);
        rec_byte("tok0", 8'hA5);
        rec_byte("tok1", 8'h00);
        chk("tok_done", 16'(out_valid), 16'd0);

        // DATA0, 5 bytes, last coincident with pkt_end
        tx_q = '{8'h01, 8'h02, 8'h03, 8'hC5, 8'h7A};
        send_pkt(4'b0011, 11'h000, 1'b1, 5);
        ts_bytes();
        rec_byte("d0_hdr", 8'h83);
        rec_byte("d0_len", 8'h05);
        rec_byte("d0_b0", 8'h01);
        rec_byte("d0_b1", 8'h02);
        rec_byte("d0_b2", 8'h03);
        rec_byte("d0_b3", 8'hC5);
        rec_byte("d0_b4", 8'h7A);
        chk("d0_done", 16'(out_valid), 16'd0);

        // NAK with stray bytes: header + LEN only
        tx_q = '{8'hEE, 8'hDD};
        send_pkt(4'b1010, 11'h000, 1'b1, 2);
        ts_bytes();
        rec_byte("nak_hdr", 8'h8A);
        rec_byte("nak_len", 8'h02);
        chk("nak_done", 16'(out_valid), 16'd0);

        // DATA1 overflow: DEPTH+3 bytes
        tx_q.delete();
        for (int i = 0; i < 67; i++) tx_q.push_back(8'(i));
        send_pkt(4'b1011, 11'h000, 1'b1, 67);
        ts_bytes();
        rec_byte("ovf_hdr", 8'hCB);
        rec_byte("ovf_len", 8'h40);
        for (int i = 0; i < 64; i++) rec_byte($sformatf("ovf_b%0d", i), 8'(i));
        chk("ovf_done", 16'(out_valid), 16'd0);

        // Back-pressure mid-payload plus a dropped packet
        tx_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        send_pkt(4'b0011, 11'h000, 1'b1, 8);
        ts_bytes();
        rec_byte("bp_hdr", 8'h83);
        rec_byte("bp_len", 8'h08);
        rec_byte("bp_b0", 8'h10);
        rec_byte("bp_b1", 8'h11);
        rec_byte("bp_b2", 8'h12);
        out_ready = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pkt_start   = (i == 3);
            rx_data_put = (i == 5);
            rx_data     = 8'h99;
            pkt_end     = (i == 6);
            pid         = 4'b0010;
            if (!(out_valid === 1'b1 && out_data === 8'h13)) stable = 1'b0;
            @(negedge clk);
        end
        pkt_start = 1'b0; rx_data_put = 1'b0; pkt_end = 1'b0;
        chk("bp_stall_stable", 16'(stable), 16'd1);
        chk("bp_stall_data", 16'(out_data), 16'h13);
        chk("bp_drop1", 16'(drop_count), 16'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_pulse_data", 16'(out_data), 16'h14);
        @(negedge clk);
        chk("bp_pulse_hold", 16'(out_data), 16'h14);
        out_ready = 1'b1;
        rec_byte("bp_b4", 8'h14);
        rec_byte("bp_b5", 8'h15);
        rec_byte("bp_b6", 8'h16);
        rec_byte("bp_b7", 8'h17);
        chk("bp_done", 16'(out_valid), 16'd0);
        repeat (5) @(negedge clk);
        chk("bp_no_second", 16'(out_valid), 16'd0);
        chk("bp_drop_final", 16'(drop_count), 16'd1);

        // Reset during PAYLOAD
        tx_q = '{8'h20, 8'h21, 8'h22, 8'h23};
        send_pkt(4'b0011, 11'h000, 1'b1, 4);
        ts_bytes();
        rec_byte("rp_hdr", 8'h83);
        rec_byte("rp_len", 8'h04);
        rec_byte("rp_b0", 8'h20);
        reset = 1'b0;
        #1;
        chk("rp_valid", 16'(out_valid), 16'd0);
        chk("rp_data", 16'(out_data), 16'h00);
        chk("rp_drop", 16'(drop_count), 16'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rp_idle", 16'(out_valid), 16'd0);

        // ACK afterwards
        send_pkt(4'b0010, 11'h000, 1'b1, 0);
        ts_bytes();
        rec_byte("ack_hdr", 8'h82);
        rec_byte("ack_len", 8'h00);
        chk("ack_done", 16'(out_valid), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
